// File: rtl/lsu_mem_stage.sv
// Memory-access stage after the ALU: drives a req/gnt/rvalid data bus for loads/stores,
// aligns and extends load data, and emits one writeback/exception pulse per accepted op.
module lsu_mem_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic                 i_Load,
    input  logic                 i_Store,
    input  logic [2:0]           i_Funct3,
    input  logic [WORD_SIZE-1:0] i_Addr,
    input  logic [WORD_SIZE-1:0] i_StoreData,
    input  logic [4:0]           i_Rd,
    output logic                 o_MemReq,
    output logic                 o_MemWe,
    output logic [WORD_SIZE-1:0] o_MemAddr,
    output logic [3:0]           o_MemBe,
    output logic [WORD_SIZE-1:0] o_MemWData,
    input  logic                 i_MemGnt,
    input  logic                 i_MemRValid,
    input  logic [WORD_SIZE-1:0] i_MemRData,
    output logic                 o_WbValid,
    output logic                 o_WbWe,
    output logic [4:0]           o_WbRd,
    output logic [WORD_SIZE-1:0] o_WbData,
    output logic                 o_Exc,
    output logic [1:0]           o_ExcCause,
    output logic [WORD_SIZE-1:0] o_ExcAddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] CAUSE_LD_MIS  = 2'b01;
    localparam logic [1:0] CAUSE_ST_MIS  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    state_e               state_q,    state_d;
    logic                 store_q,    store_d;
    logic [2:0]           funct3_q,   funct3_d;
    logic [WORD_SIZE-1:0] addr_q,     addr_d;
    logic [3:0]           be_q,       be_d;
    logic [WORD_SIZE-1:0] wdata_q,    wdata_d;
    logic [4:0]           rd_q,       rd_d;
    logic                 wb_we_q,    wb_we_d;
    logic [WORD_SIZE-1:0] wb_data_q,  wb_data_d;
    logic                 exc_q,      exc_d;
    logic [1:0]           cause_q,    cause_d;

    logic                 illegal;
    logic                 misaligned;
    logic [WORD_SIZE-1:0] rdata_shifted;
    logic [WORD_SIZE-1:0] load_data;

    // Decode of the op presented in IDLE.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (i_Load && i_Store) begin
            illegal = 1'b1;
        end else if (i_Load) begin
            illegal = (i_Funct3 == 3'd3) || (i_Funct3 == 3'd6) || (i_Funct3 == 3'd7);
        end else if (i_Store) begin
            illegal = (i_Funct3 >= 3'd3);
        end
        case (i_Funct3[1:0])
            2'd1:    misaligned = i_Addr[0];
            2'd2:    misaligned = (i_Addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Load alignment uses the captured address offset and width code.
    always_comb begin
        rdata_shifted = i_MemRData >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            F3_B:    load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            F3_BU:   load_data = {24'h0, rdata_shifted[7:0]};
            F3_H:    load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3_HU:   load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_we_d   = wb_we_q;
        wb_data_d = wb_data_q;
        exc_d     = exc_q;
        cause_d   = cause_q;

        case (state_q)
            S_IDLE: begin
                if (i_Valid) begin
                    store_d   = i_Store;
                    funct3_d  = i_Funct3;
                    addr_d    = i_Addr;
                    rd_d      = i_Rd;
                    be_d      = 4'b0000;
                    wdata_d   = '0;
                    wb_we_d   = 1'b0;
                    wb_data_d = '0;
                    exc_d     = 1'b0;
                    cause_d   = 2'b00;
                    if (!i_Load && !i_Store) begin
                        wb_data_d = i_Addr;
                        wb_we_d   = (i_Rd != 5'd0);
                        state_d   = S_RESP;
                    end else if (illegal) begin
                        exc_d   = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_RESP;
                    end else if (misaligned) begin
                        exc_d   = 1'b1;
                        cause_d = i_Load ? CAUSE_LD_MIS : CAUSE_ST_MIS;
                        state_d = S_RESP;
                    end else begin
                        case (i_Funct3[1:0])
                            2'd0: begin
                                be_d    = 4'b0001 << i_Addr[1:0];
                                wdata_d = {4{i_StoreData[7:0]}};
                            end
                            2'd1: begin
                                be_d    = 4'b0011 << i_Addr[1:0];
                                wdata_d = {2{i_StoreData[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = i_StoreData;
                            end
                        endcase
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_MemGnt) begin
                    state_d = store_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_MemRValid) begin
                    wb_data_d = load_data;
                    wb_we_d   = (rd_q != 5'd0);
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            store_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            rd_q      <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
            exc_q     <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_we_q   <= wb_we_d;
            wb_data_q <= wb_data_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

    // Bus and writeback fields are forced to zero outside the state that qualifies them.
    always_comb begin
        o_Ready    = (state_q == S_IDLE) && i_Rst_n;
        o_MemReq   = (state_q == S_REQ);
        o_MemWe    = o_MemReq && store_q;
        o_MemAddr  = o_MemReq ? {addr_q[WORD_SIZE-1:2], 2'b00} : '0;
        o_MemBe    = o_MemReq ? be_q : 4'b0000;
        o_MemWData = o_MemReq ? wdata_q : '0;
        o_WbValid  = (state_q == S_RESP);
        o_WbWe     = o_WbValid && wb_we_q;
        o_WbRd     = o_WbValid ? rd_q : 5'd0;
        o_WbData   = o_WbValid ? wb_data_q : '0;
        o_Exc      = o_WbValid && exc_q;
        o_ExcCause = o_Exc ? cause_q : 2'b00;
        o_ExcAddr  = o_Exc ? addr_q : '0;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: non-memory ops, stores, loads with alignment and
// extension, exceptions, zero-wait timing, and reset abort.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.WORD_SIZE(32)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Valid     (valid),
        .o_Ready     (ready),
        .i_Load      (load),
        .i_Store     (store),
        .i_Funct3    (funct3),
        .i_Addr      (addr),
        .i_StoreData (store_data),
        .i_Rd        (rd),
        .o_MemReq    (mem_req),
        .o_MemWe     (mem_we),
        .o_MemAddr   (mem_addr),
        .o_MemBe     (mem_be),
        .o_MemWData  (mem_wdata),
        .i_MemGnt    (mem_gnt),
        .i_MemRValid (mem_rvalid),
        .i_MemRData  (mem_rdata),
        .o_WbValid   (wb_valid),
        .o_WbWe      (wb_we),
        .o_WbRd      (wb_rd),
        .o_WbData    (wb_data),
        .o_Exc       (exc),
        .o_ExcCause  (exc_cause),
        .o_ExcAddr   (exc_addr)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
        valid = 1'b1; load = ld; store = st; funct3 = f3;
        addr = a; store_data = sd; rd = r;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0;
        addr = 32'h0; store_data = 32'h0; rd = 5'd0;
    endtask

    // Zero-wait load: accept, gnt next cycle, rvalid the cycle after; returns in RESP.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] r, input logic [31:0] rdata);
        present(1'b1, 1'b0, f3, a, 32'h0, r);
        tick();
        idle_inputs();
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        idle_inputs();
        #12;
        check("rst_ready",   32'(ready),    32'd0);
        check("rst_wbvalid", 32'(wb_valid), 32'd0);
        check("rst_memreq",  32'(mem_req),  32'd0);
        rst_n = 1'b1;
        #2;
        check("idle_ready", 32'(ready), 32'd1);

        // 1. Non-memory op
        present(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        idle_inputs();
        check("alu_wbvalid", 32'(wb_valid), 32'd1);
        check("alu_wbwe",    32'(wb_we),    32'd1);
        check("alu_wbrd",    32'(wb_rd),    32'd5);
        check("alu_wbdata",  wb_data,       32'h0000_1234);
        check("alu_memreq",  32'(mem_req),  32'd0);
        check("alu_exc",     32'(exc),      32'd0);
        tick();
        check("alu_pulse_end", 32'(wb_valid), 32'd0);
        check("alu_ready",     32'(ready),    32'd1);

        // 2. SB with two wait cycles before gnt
        present(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd7);
        tick();
        idle_inputs();
        for (int w = 0; w < 3; w++) begin
            check("sb_req",   32'(mem_req), 32'd1);
            check("sb_we",    32'(mem_we),  32'd1);
            check("sb_addr",  mem_addr,     32'h0000_0100);
            check("sb_be",    32'(mem_be),  32'h8);
            check("sb_wdata", mem_wdata,    32'hABAB_ABAB);
            check("sb_wbvalid_early", 32'(wb_valid), 32'd0);
            if (w == 2) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        check("sb_wbvalid", 32'(wb_valid), 32'd1);
        check("sb_wbwe",    32'(wb_we),    32'd0);
        check("sb_exc",     32'(exc),      32'd0);
        check("sb_req_off", 32'(mem_req),  32'd0);
        check("sb_be_off",  32'(mem_be),   32'h0);
        tick();

        // SH at offset 2 and SW byte enables / data replication
        present(1'b0, 1'b1, 3'd1, 32'h0000_0402, 32'h1234_BEEF, 5'd0);
        tick();
        idle_inputs();
        check("sh_be",    32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata,   32'hBEEF_BEEF);
        check("sh_addr",  mem_addr,    32'h0000_0400);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sh_wbvalid", 32'(wb_valid), 32'd1);
        tick();

        // 3. Load alignment / extension
        run_load(3'd1, 32'h0000_0202, 5'd3, 32'h8001_5555);
        check("lh_wbvalid", 32'(wb_valid), 32'd1);
        check("lh_wbwe",    32'(wb_we),    32'd1);
        check("lh_wbrd",    32'(wb_rd),    32'd3);
        check("lh_data",    wb_data,       32'hFFFF_8001);
        tick();
        run_load(3'd5, 32'h0000_0202, 5'd3, 32'h8001_5555);
        check("lhu_data", wb_data, 32'h0000_8001);
        tick();
        run_load(3'd0, 32'h0000_0201, 5'd4, 32'h0000_7F00);
        check("lb_data", wb_data, 32'h0000_007F);
        tick();
        run_load(3'd0, 32'h0000_0203, 5'd4, 32'h8000_0000);
        check("lb_neg_data", wb_data, 32'hFFFF_FF80);
        tick();
        run_load(3'd4, 32'h0000_0203, 5'd4, 32'h8000_0000);
        check("lbu_data", wb_data, 32'h0000_0080);
        tick();
        run_load(3'd2, 32'h0000_0104, 5'd9, 32'hDEAD_BEEF);
        check("lw_data", wb_data, 32'hDEAD_BEEF);
        tick();

        // 4. Exceptions
        present(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd6);
        tick();
        idle_inputs();
        check("lw_mis_wbvalid", 32'(wb_valid),  32'd1);
        check("lw_mis_exc",     32'(exc),       32'd1);
        check("lw_mis_cause",   32'(exc_cause), 32'd1);
        check("lw_mis_addr",    exc_addr,       32'h0000_0102);
        check("lw_mis_wbwe",    32'(wb_we),     32'd0);
        check("lw_mis_req",     32'(mem_req),   32'd0);
        tick();
        check("lw_mis_no_req", 32'(mem_req), 32'd0);

        present(1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h0, 5'd0);
        tick();
        idle_inputs();
        check("sh_mis_exc",   32'(exc),       32'd1);
        check("sh_mis_cause", 32'(exc_cause), 32'd2);
        check("sh_mis_addr",  exc_addr,       32'h0000_0101);
        tick();

        present(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0, 5'd1);
        tick();
        idle_inputs();
        check("ld_f3_cause", 32'(exc_cause), 32'd3);
        check("ld_f3_wbwe",  32'(wb_we),     32'd0);
        tick();

        present(1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0, 5'd0);
        tick();
        idle_inputs();
        check("st_f3_cause", 32'(exc_cause), 32'd3);
        tick();

        present(1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 5'd1);
        tick();
        idle_inputs();
        check("ldst_cause", 32'(exc_cause), 32'd3);
        check("ldst_req",   32'(mem_req),   32'd0);
        tick();

        // 5. Zero-wait LW to rd=0 with spurious rvalid in IDLE and REQ
        present(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 5'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        idle_inputs();
        check("zw_ready_req", 32'(ready),   32'd0);
        check("zw_req",       32'(mem_req), 32'd1);
        check("zw_we",        32'(mem_we),  32'd0);
        check("zw_be",        32'(mem_be),  32'hF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("zw_ready_wait", 32'(ready),    32'd0);
        check("zw_req_wait",   32'(mem_req),  32'd0);
        check("zw_no_early",   32'(wb_valid), 32'd0);
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("zw_wbvalid", 32'(wb_valid), 32'd1);
        check("zw_wbwe",    32'(wb_we),    32'd0);
        check("zw_data",    wb_data,       32'hCAFE_F00D);
        check("zw_ready_resp", 32'(ready), 32'd0);
        tick();
        check("zw_ready_done", 32'(ready),    32'd1);
        check("zw_pulse_end",  32'(wb_valid), 32'd0);

        // 6. Reset during WAIT
        present(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd8);
        tick();
        idle_inputs();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rw_in_wait", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_ready",   32'(ready),    32'd0);
        check("rw_req",     32'(mem_req),  32'd0);
        check("rw_wbvalid", 32'(wb_valid), 32'd0);
        check("rw_wbdata",  wb_data,       32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rw_ready_after", 32'(ready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        check("rw_no_stale", 32'(wb_valid), 32'd0);
        check("rw_idle",     32'(ready),    32'd1);

        // Reset during REQ drops the bus request immediately
        present(1'b0, 1'b1, 3'd2, 32'h0000_0600, 32'h1, 5'd0);
        tick();
        idle_inputs();
        check("rr_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_req_drop",  32'(mem_req), 32'd0);
        check("rr_addr_drop", mem_addr,     32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_no_stale", 32'(wb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
